// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU (m0) and a
// loader/DMA engine (m1). Round-robin on contention, bounded m1 bursts under
// lock, and read data steered back to the master that issued the read.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0: CPU load/store path
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [3:0]            m0_wmask,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  // master 1: loader/DMA engine
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [3:0]            m1_wmask,
  input  logic                  m1_last,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  // data memory port
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {
    ARB     = 1'b0,
    M1_LOCK = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic             last_gnt, last_gnt_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt, beat_inc;
  logic             rd_pend, rd_pend_nxt;
  logic             rd_sel, rd_sel_nxt;
  logic             gnt0, gnt1;

  // State and bookkeeping registers; reset drops any lock or pending read at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      last_gnt <= 1'b1;
      beat_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_sel   <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      beat_cnt <= beat_cnt_nxt;
      rd_pend  <= rd_pend_nxt;
      rd_sel   <= rd_sel_nxt;
    end
  end

  // Grant decision, burst lock tracking and read-return bookkeeping
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    beat_cnt_nxt = beat_cnt;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    beat_inc     = beat_cnt + CNT_W'(1);

    case (state)
      ARB: begin
        // On a tie the master that did not go last wins
        gnt0 = m0_req && (!m1_req || last_gnt);
        gnt1 = m1_req && (!m0_req || !last_gnt);
        if (gnt0) begin
          last_gnt_nxt = 1'b0;
        end
        if (gnt1) begin
          last_gnt_nxt = 1'b1;
          if (!m1_last && (MAX_BURST > 1)) begin
            state_nxt    = M1_LOCK;
            beat_cnt_nxt = CNT_W'(1);
          end
        end
      end
      M1_LOCK: begin
        // m0 is shut out; idle m1 cycles keep the lock
        gnt1 = m1_req;
        if (gnt1) begin
          last_gnt_nxt = 1'b1;
          if (m1_last || (beat_inc == CNT_W'(MAX_BURST))) begin
            state_nxt    = ARB;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_inc;
          end
        end
      end
      default: begin
        state_nxt = ARB;
      end
    endcase

    rd_pend_nxt = (gnt0 && !m0_we) || (gnt1 && !m1_we);
    rd_sel_nxt  = rd_pend_nxt ? gnt1 : rd_sel;
  end

  // Memory port mux: idle port is fully quiet
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_we    = 1'b0;
    if (gnt0) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_wmask = m0_wmask;
      mem_we    = m0_we;
    end else if (gnt1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_wmask = m1_wmask;
      mem_we    = m1_we;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rd_pend && !rd_sel;
  assign m1_rvalid = rd_pend && rd_sel;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [3:0]    m0_wmask;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_last;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [3:0]    m1_wmask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  logic [31:0] mem [0:8191];

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_last(m1_last),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous data memory: read-before-write, one-cycle read latency
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[AW-1:2]];
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) mem[mem_addr[AW-1:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
    m1_last = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    mem[15'h10 >> 2] = 32'hDEADBEEF;
    mem[15'h20 >> 2] = 32'hAABBCCDD;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst_m1_rvalid", m1_rvalid, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_wmask", mem_wmask, 4'h0);
    chk("rst_m0_gnt", m0_gnt, 1'b0);
    chk("rst_m1_gnt", m1_gnt, 1'b0);
    @(negedge clk); rst = 1'b0;

    // m0 single read of 0x10
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 15'h10;
    #1;
    chk("rd0_m0_gnt", m0_gnt, 1'b1);
    chk("rd0_m1_gnt", m1_gnt, 1'b0);
    chk("rd0_mem_addr", mem_addr, 15'h10);
    chk("rd0_mem_we", mem_we, 1'b0);
    chk("rd0_m1_rvalid_c0", m1_rvalid, 1'b0);
    @(negedge clk); idle();
    #1;
    chk("rd0_m0_rvalid", m0_rvalid, 1'b1);
    chk("rd0_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd0_m1_rvalid", m1_rvalid, 1'b0);
    @(negedge clk);
    #1;
    chk("rd0_m0_rvalid_drop", m0_rvalid, 1'b0);

    // Fresh reset, then continuous contention with single-beat m1
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 15'h200; m0_wdata = 32'(i); m0_wmask = 4'hF;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 15'h204; m1_wdata = 32'(i); m1_wmask = 4'hF;
      m1_last = 1'b1;
      #1;
      chk("alt_m0_gnt", m0_gnt, (i % 2) == 0);
      chk("alt_m1_gnt", m1_gnt, (i % 2) == 1);
      chk("alt_one_gnt", m0_gnt & m1_gnt, 1'b0);
    end

    // m1 burst of 4 writes ending on m1_last, m0 waiting behind it
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      m0_req = (b != 0); m0_we = 1'b1; m0_addr = 15'h300; m0_wdata = 32'h55; m0_wmask = 4'hF;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = AW'(15'h100 + 4 * b);
      m1_wdata = 32'hA000_0000 + 32'(b); m1_wmask = 4'hF; m1_last = (b == 3);
      #1;
      chk("b4_m1_gnt", m1_gnt, 1'b1);
      chk("b4_m0_gnt", m0_gnt, 1'b0);
      chk("b4_mem_addr", mem_addr, AW'(15'h100 + 4 * b));
    end
    @(negedge clk);
    m1_req = 1'b0; m1_last = 1'b0;
    #1;
    chk("b4_m0_after", m0_gnt, 1'b1);
    @(negedge clk); idle();
    #1;
    for (int b = 0; b < 4; b++) chk("b4_mem_word", mem[(15'h100 >> 2) + b], 32'hA000_0000 + 32'(b));

    // m1 burst without m1_last: capped at 8 beats, then m0, then m1 again
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      m0_req = (c != 11); m0_we = 1'b1; m0_addr = 15'h500; m0_wdata = 32'h66; m0_wmask = 4'hF;
      m1_req = (c != 10); m1_we = 1'b1; m1_addr = 15'h400; m1_wdata = 32'h77; m1_wmask = 4'hF;
      m1_last = (c == 11);
      #1;
      chk("b8_m1_gnt", m1_gnt, (c < 8) || (c == 9) || (c == 11));
      chk("b8_m0_gnt", m0_gnt, c == 8);
    end

    // Masked m0 write then m1 read-back of the same word
    @(negedge clk); idle();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 15'h20; m0_wdata = 32'h11223344; m0_wmask = 4'b0011;
    #1;
    chk("mw_m0_gnt", m0_gnt, 1'b1);
    chk("mw_mem_we", mem_we, 1'b1);
    chk("mw_mem_wmask", mem_wmask, 4'b0011);
    @(negedge clk); idle();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 15'h20; m1_last = 1'b1;
    #1;
    chk("mw_m1_gnt", m1_gnt, 1'b1);
    chk("mw_mem_we_rd", mem_we, 1'b0);
    @(negedge clk); idle();
    #1;
    chk("mw_m1_rvalid", m1_rvalid, 1'b1);
    chk("mw_m1_rdata", m1_rdata, 32'hAABB3344);
    chk("mw_m0_rvalid", m0_rvalid, 1'b0);

    // Reset while locked with an m1 read outstanding
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 15'h10; m1_last = 1'b0;
    #1;
    chk("rl_m1_gnt0", m1_gnt, 1'b1);
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 15'h20;
    m1_addr = 15'h14;
    #1;
    chk("rl_m1_gnt1", m1_gnt, 1'b1);
    chk("rl_m0_locked_out", m0_gnt, 1'b0);
    @(negedge clk); idle();
    rst = 1'b1;
    #1;
    chk("rl_m1_rvalid_rst", m1_rvalid, 1'b0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rl_m1_rvalid_post", m1_rvalid, 1'b0);
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 15'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 15'h20; m1_last = 1'b1;
    #1;
    chk("rl_tie_m0_gnt", m0_gnt, 1'b1);
    chk("rl_tie_m1_gnt", m1_gnt, 1'b0);
    @(negedge clk); idle();
    #1;
    chk("rl_m0_rvalid", m0_rvalid, 1'b1);
    chk("rl_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rl_m1_rvalid_end", m1_rvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
